unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port, synchronous-read 32-bit memory between three requesters: the external program loader (we0/wr_addr0/wr_din0 path), the MEM-stage data port and the IF-stage instruction fetch.
Sits between the pipeline top level and the memory macro.
- Sequences loader bursts.
- Arbitrates fetch against data accesses, with starvation protection for fetch.
- Routes read data back to whichever requester issued the read.
- Drives a fetch-stall signal into the pipeline hazard logic.

Parameters:
AW, 9, address width (words addressed as in Data_mem, 9-bit).
DW, 32, data width.
STARVE_MAX, 3, consecutive denied fetch cycles after which fetch beats the data port for one grant.
CW, 10, width of loaded-word counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
ld_req  in  1  loader write strobe (one word per cycle while high).
ld_addr  in  AW  loader write address.
ld_wdata  in  DW  loader write data.
if_req  in  1  fetch read request.
if_addr  in  AW  fetch address.
if_gnt  out  1  fetch accepted this cycle (combinational).
if_rvalid  out  1  fetch read data valid (one cycle after grant).
if_rdata  out  DW  fetch read data.
dm_req  in  1  data-port request.
dm_we  in  1  1 = write, 0 = read.
dm_strb  in  4  byte strobes for writes.
dm_addr  in  AW  data address.
dm_wdata  in  DW  data write data.
dm_gnt  out  1  data access accepted this cycle (combinational).
dm_rvalid  out  1  data read valid (one cycle after read grant).
dm_rdata  out  DW  data read data.
mem_en  out  1  memory access enable.
mem_we  out  1  memory write enable.
mem_strb  out  4  memory byte strobes.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data (valid the cycle after mem_en with mem_we=0).
stall_if  out  1  if_req & ~if_gnt; pipeline must hold PC and IF/ID.
load_busy  out  1  high in LOAD and DRAIN states.
ld_count  out  CW  words written since entering LOAD.

Behaviour:
Reset values:
- state=RUN; all gnt/rvalid=0; mem_en=0; starve_cnt=0; rd_owner=NONE; ld_count=0.
- rdata outputs=0 while their rvalid=0.

FSM states: RUN, LOAD, DRAIN.
- RUN -> LOAD when ld_req=1. The loader is granted that same cycle.
- LOAD -> DRAIN on the first cycle ld_req=0.
- DRAIN -> RUN after exactly 1 cycle. DRAIN issues no grants, giving the pipeline a cycle to apply resetpc.

LOAD state:
- mem_en=1, mem_we=1, mem_strb=4'hF, address/data taken from the loader, only while ld_req=1.
- if_gnt=dm_gnt=0.
- ld_count increments per written word; it saturates at all-ones.
- ld_count clears on RUN->LOAD, then counts the entry word, so it reads 1 after the first word.

RUN arbitration (combinational in the request cycle):
- Default priority: dm over if.
- If starve_cnt==STARVE_MAX and if_req=1, fetch wins and dm_gnt=0.
- The granted requester drives mem_*. Fetch uses mem_we=0 and mem_strb=0.
- Exactly one grant or none per cycle; mem_en=|grants.

starve_cnt:
- Increments when if_req & ~if_gnt in RUN, saturating at STARVE_MAX.
- Clears on if_gnt or when if_req=0.
- Frozen in LOAD/DRAIN.

Read return:
- On a read grant, register rd_owner (IF or DM); otherwise rd_owner=NONE next cycle.
- Next cycle, the owner's rvalid=1 and its rdata=mem_rdata; the other rdata=0.
- Writes never produce rvalid.
- A read granted on the last RUN cycle before LOAD still returns its rvalid in the first LOAD cycle.

Simultaneous events:
- ld_req has absolute priority over if_req and dm_req in every state except DRAIN, where it is ignored (no grant, loader must hold).
- Requesters hold req/addr until gnt.

Reset mid-operation:
- Asynchronous return to reset values regardless of state.
- An outstanding rvalid is dropped.

Decomposition:
- Shared package: state encoding (RUN=2'd0, LOAD=2'd1, DRAIN=2'd2) and owner encoding (NONE, IF, DM).
- One natural sub-module: mem_rr_prio, holding starve_cnt and the fetch/data grant logic.
- The FSM, loader counter and read-return routing stay in the top module.

Test Plan:
1. Reset then if_req=1, if_addr=9'h004, mem_rdata=32'h00500093 -> if_gnt=1 same cycle, mem_addr=4; next cycle if_rvalid=1, if_rdata=32'h00500093, dm_rvalid=0.
2. if_req and dm_req (read, addr 9'h010) both held high -> dm granted 3 cycles, stall_if=1 during those 3 cycles; 4th cycle if_gnt=1, dm_gnt=0 (STARVE_MAX=3).
3. dm write: dm_we=1, strb=4'b0011, addr 9'h020, wdata 32'hDEADBEEF -> mem_we=1, mem_strb=4'b0011 same cycle; no dm_rvalid next cycle.
4. ld_req high 5 cycles (addr 0..4) with if_req high -> 5 writes, if_gnt=0 throughout, ld_count=5, load_busy=1; then 1 DRAIN cycle with no grants; RUN resumes and if_gnt=1.
5. Fetch read granted at cycle N, ld_req rises at N+1 -> if_rvalid=1 at N+1 while loader writes at N+1.
6. Assert reset while in LOAD with ld_count=3 -> immediately state RUN, ld_count=0, mem_en=0, no rvalid.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and sizing for the unified memory arbiter.
package unified_mem_arbiter_pkg;

    localparam int unsigned AW         = 9;
    localparam int unsigned DW         = 32;
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned CW         = 10;
    localparam int unsigned SW         = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

endpackage

// File: rtl/unified_mem_arbiter_mem_rr_prio.sv
// Fetch/data grant logic with starvation protection for the fetch port.
module mem_rr_prio
    import unified_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic allow,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    // Data port wins by default; a starved fetch takes one grant.
    always_comb begin
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        starved = (starve_cnt == SW'(STARVE_MAX));
        if (allow) begin
            if (if_req && starved) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Count consecutive denied fetch cycles; frozen outside RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (run) begin
            if (!if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between loader, data port and fetch.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_strb,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_strb,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          load_busy,
    output logic [CW-1:0] ld_count
);

    state_e state, state_nxt;
    owner_e rd_owner;
    logic   run, allow;

    assign run   = (state == RUN);
    assign allow = run && !ld_req;

    mem_rr_prio u_prio (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .allow  (allow),
        .if_req (if_req),
        .dm_req (dm_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory port mux; the loader pre-empts everyone outside DRAIN.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_strb  = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            RUN: begin
                if (ld_req) begin
                    state_nxt = LOAD;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_strb  = 4'hF;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_wdata;
                end else if (dm_gnt) begin
                    mem_en    = 1'b1;
                    mem_we    = dm_we;
                    mem_strb  = dm_we ? dm_strb : 4'h0;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wdata;
                end else if (if_gnt) begin
                    mem_en    = 1'b1;
                    mem_addr  = if_addr;
                end
            end
            LOAD: begin
                if (ld_req) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_strb  = 4'hF;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_wdata;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Loaded-word counter: restarts at 1 on the entry word, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_count <= '0;
        end else if (run && ld_req) begin
            ld_count <= CW'(1);
        end else if (state == LOAD && ld_req && ld_count != '1) begin
            ld_count <= ld_count + CW'(1);
        end
    end

    // Remember who issued the read so next-cycle data goes to the right port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else if (if_gnt) begin
            rd_owner <= OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            rd_owner <= OWN_DM;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign if_rvalid = (rd_owner == OWN_IF);
    assign dm_rvalid = (rd_owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    assign stall_if  = if_req && !if_gnt;
    assign load_busy = !run;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a random run against a reference model.
module tb_unified_mem_arbiter;

    logic        clk, reset;
    logic        ld_req;
    logic [8:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [3:0]  dm_strb;
    logic [8:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_strb;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_if, load_busy;
    logic [9:0]  ld_count;

    int n_checks = 0;
    int n_fail   = 0;

    unified_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_strb(dm_strb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .load_busy(load_busy), .ld_count(ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ld_req = 0; ld_addr = '0; ld_wdata = '0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_strb = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got if=%b dm=%b exp 0 0", if_gnt, dm_gnt); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
        n_checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got if=%b dm=%b exp 0 0", if_rvalid, dm_rvalid); end
        n_checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got if=%h dm=%h exp 0 0", if_rdata, dm_rdata); end
        n_checks++; if (ld_count !== 10'd0 || load_busy !== 1'b0) begin n_fail++; $display("FAIL reset_load got cnt=%0d busy=%b exp 0 0", ld_count, load_busy); end
        @(negedge clk);
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_fetch_basic();
        if_req = 1; if_addr = 9'h004; mem_rdata = 32'h00500093;
        @(negedge clk);
        n_checks++; if (if_gnt !== 1'b1 || mem_addr !== 9'h004 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
            n_fail++; $display("FAIL fetch_grant got gnt=%b addr=%h we=%b en=%b exp 1 004 0 1", if_gnt, mem_addr, mem_we, mem_en); end
        next_cycle();
        if_req = 0;
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || dm_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL fetch_return got rv=%b rd=%h dmrv=%b exp 1 00500093 0", if_rvalid, if_rdata, dm_rvalid); end
        next_cycle();
        mem_rdata = '0;
    endtask

    task automatic test_starvation();
        if_req = 1; if_addr = 9'h008;
        dm_req = 1; dm_we = 0; dm_addr = 9'h010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || stall_if !== 1'b1 || mem_addr !== 9'h010) begin
                n_fail++; $display("FAIL starve_dm_win[%0d] got dm=%b if=%b stall=%b addr=%h exp 1 0 1 010", i, dm_gnt, if_gnt, stall_if, mem_addr); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || stall_if !== 1'b0 || mem_addr !== 9'h008) begin
            n_fail++; $display("FAIL starve_if_win got if=%b dm=%b stall=%b addr=%h exp 1 0 0 008", if_gnt, dm_gnt, stall_if, mem_addr); end
        next_cycle();
        if_req = 0; dm_req = 0;
        next_cycle();
    endtask

    task automatic test_dm_write();
        dm_req = 1; dm_we = 1; dm_strb = 4'b0011; dm_addr = 9'h020; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++; if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_strb !== 4'b0011 || mem_addr !== 9'h020 || mem_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL dm_write got gnt=%b we=%b strb=%b addr=%h wd=%h", dm_gnt, mem_we, mem_strb, mem_addr, mem_wdata); end
        next_cycle();
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        n_checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL dm_write_no_rvalid got dm=%b if=%b exp 0 0", dm_rvalid, if_rvalid); end
        next_cycle();
    endtask

    task automatic test_load_burst();
        logic [31:0] wd;
        if_req = 1; if_addr = 9'h00C;
        for (int i = 0; i < 5; i++) begin
            wd = $urandom;
            ld_req = 1; ld_addr = 9'(i); ld_wdata = wd;
            @(negedge clk);
            n_checks++; if (if_gnt !== 1'b0 || mem_we !== 1'b1 || mem_strb !== 4'hF || mem_addr !== 9'(i) || mem_wdata !== wd) begin
                n_fail++; $display("FAIL load_word[%0d] got ifg=%b we=%b strb=%h addr=%h wd=%h exp wd=%h", i, if_gnt, mem_we, mem_strb, mem_addr, mem_wdata, wd); end
            next_cycle();
        end
        ld_req = 0;
        @(negedge clk);
        n_checks++; if (ld_count !== 10'd5 || load_busy !== 1'b1 || mem_en !== 1'b0 || if_gnt !== 1'b0) begin
            n_fail++; $display("FAIL load_end got cnt=%0d busy=%b en=%b ifg=%b exp 5 1 0 0", ld_count, load_busy, mem_en, if_gnt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (load_busy !== 1'b1 || mem_en !== 1'b0 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
            n_fail++; $display("FAIL drain got busy=%b en=%b ifg=%b dmg=%b exp 1 0 0 0", load_busy, mem_en, if_gnt, dm_gnt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (if_gnt !== 1'b1 || load_busy !== 1'b0 || mem_addr !== 9'h00C) begin
            n_fail++; $display("FAIL run_resume got ifg=%b busy=%b addr=%h exp 1 0 00c", if_gnt, load_busy, mem_addr); end
        next_cycle();
        if_req = 0;
        next_cycle();
    endtask

    task automatic test_read_before_load();
        if_req = 1; if_addr = 9'h030;
        @(negedge clk);
        n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL pre_load_grant got %b exp 1", if_gnt); end
        next_cycle();
        if_req = 0; ld_req = 1; ld_addr = 9'h040; ld_wdata = 32'h11111111; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hCAFEF00D || mem_we !== 1'b1 || mem_addr !== 9'h040) begin
            n_fail++; $display("FAIL read_across_load got rv=%b rd=%h we=%b addr=%h exp 1 cafef00d 1 040", if_rvalid, if_rdata, mem_we, mem_addr); end
        next_cycle();
        mem_rdata = '0; ld_addr = 9'h041;
        next_cycle();
        ld_addr = 9'h042;
        next_cycle();
    endtask

    task automatic test_reset_mid_load();
        n_checks++; if (ld_count !== 10'd3 || load_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_load_count got cnt=%0d busy=%b exp 3 1", ld_count, load_busy); end
        reset = 1; ld_req = 0;
        #1;
        n_checks++; if (ld_count !== 10'd0 || load_busy !== 1'b0 || mem_en !== 1'b0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_load got cnt=%0d busy=%b en=%b ifrv=%b dmrv=%b exp 0 0 0 0 0", ld_count, load_busy, mem_en, if_rvalid, dm_rvalid); end
        @(negedge clk);
        reset = 0;
        next_cycle();
        // Outstanding read return is dropped by reset.
        dm_req = 1; dm_we = 0; dm_addr = 9'h055;
        next_cycle();
        dm_req = 0; mem_rdata = 32'h12345678;
        #1;
        n_checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL pre_reset_dm_rvalid got rv=%b rd=%h exp 1 12345678", dm_rvalid, dm_rdata); end
        reset = 1;
        #1;
        n_checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_drops_rvalid got rv=%b rd=%h exp 0 0", dm_rvalid, dm_rdata); end
        @(negedge clk);
        reset = 0; mem_rdata = '0;
        next_cycle();
    endtask

    // Random traffic checked against a phase/queue model built from the arbitration rules.
    task automatic test_random(input int ncyc);
        bit          ifp = 0, dmp = 0;
        logic [8:0]  ia = '0, da = '0, la = '0;
        logic        dwe = 0;
        logic [3:0]  ds = '0;
        logic [31:0] dwd = '0, lwd = '0, rd = '0;
        int          ld_left = 0;
        int          phase = 0;   // 0 normal, 1 loading, 2 settle
        int          starve = 0;
        int          owner = 0;   // 0 none, 1 fetch, 2 data
        int          cnt = 0;
        bit          ld_win, e_if, e_dm, e_en, e_we;
        logic [8:0]  e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        for (int c = 0; c < ncyc; c++) begin
            if (!ifp && $urandom_range(0, 99) < 55) begin ifp = 1; ia = 9'($urandom); end
            if (!dmp && $urandom_range(0, 99) < 45) begin
                dmp = 1; da = 9'($urandom); dwe = 1'($urandom); ds = 4'($urandom); dwd = $urandom;
            end
            if (ld_left == 0 && $urandom_range(0, 99) < 4) begin
                ld_left = $urandom_range(1, 6); la = 9'($urandom); lwd = $urandom;
            end
            rd = $urandom;
            if_req = ifp; if_addr = ia;
            dm_req = dmp; dm_we = dwe; dm_strb = ds; dm_addr = da; dm_wdata = dwd;
            ld_req = (ld_left > 0); ld_addr = la; ld_wdata = lwd;
            mem_rdata = rd;
            @(negedge clk);
            ld_win = ld_req && (phase != 2);
            e_if = 0; e_dm = 0;
            if (phase == 0 && !ld_req) begin
                if (ifp && starve >= 3) e_if = 1;
                else if (dmp)           e_dm = 1;
                else if (ifp)           e_if = 1;
            end
            e_en = ld_win || e_if || e_dm;
            e_we = ld_win || (e_dm && dwe);
            e_addr = ld_win ? la : (e_dm ? da : ia);
            e_strb = ld_win ? 4'hF : (e_dm ? ds : 4'h0);
            e_wd   = ld_win ? lwd : dwd;
            n_checks++; if (if_gnt !== e_if || dm_gnt !== e_dm) begin n_fail++; $display("FAIL rnd_gnt c=%0d got if=%b dm=%b exp %b %b", c, if_gnt, dm_gnt, e_if, e_dm); end
            n_checks++; if (mem_en !== e_en || mem_we !== e_we) begin n_fail++; $display("FAIL rnd_en_we c=%0d got en=%b we=%b exp %b %b", c, mem_en, mem_we, e_en, e_we); end
            if (e_en) begin
                n_checks++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, mem_addr, e_addr); end
            end
            if (e_we || e_if) begin
                n_checks++; if (mem_strb !== e_strb) begin n_fail++; $display("FAIL rnd_strb c=%0d got %h exp %h", c, mem_strb, e_strb); end
            end
            if (e_we) begin
                n_checks++; if (mem_wdata !== e_wd) begin n_fail++; $display("FAIL rnd_wdata c=%0d got %h exp %h", c, mem_wdata, e_wd); end
            end
            n_checks++; if (stall_if !== (ifp && !e_if)) begin n_fail++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, stall_if, ifp && !e_if); end
            n_checks++; if (load_busy !== (phase != 0) || ld_count !== 10'(cnt)) begin
                n_fail++; $display("FAIL rnd_load c=%0d got busy=%b cnt=%0d exp %b %0d", c, load_busy, ld_count, phase != 0, cnt); end
            n_checks++; if (if_rvalid !== (owner == 1) || if_rdata !== ((owner == 1) ? rd : 32'h0)) begin
                n_fail++; $display("FAIL rnd_if_ret c=%0d got rv=%b rd=%h exp owner=%0d", c, if_rvalid, if_rdata, owner); end
            n_checks++; if (dm_rvalid !== (owner == 2) || dm_rdata !== ((owner == 2) ? rd : 32'h0)) begin
                n_fail++; $display("FAIL rnd_dm_ret c=%0d got rv=%b rd=%h exp owner=%0d", c, dm_rvalid, dm_rdata, owner); end
            // Advance the model.
            owner = e_if ? 1 : ((e_dm && !dwe) ? 2 : 0);
            if (phase == 0) begin
                if (!ifp || e_if) starve = 0;
                else if (starve < 3) starve++;
            end
            if (phase == 0 && ld_req)      cnt = 1;
            else if (phase == 1 && ld_req) cnt = (cnt < 1023) ? cnt + 1 : 1023;
            if (phase == 0)      phase = ld_req ? 1 : 0;
            else if (phase == 1) phase = ld_req ? 1 : 2;
            else                 phase = 0;
            if (e_if) ifp = 0;
            if (e_dm) dmp = 0;
            if (ld_win) begin ld_left--; la = la + 9'd1; lwd = $urandom; end
            next_cycle();
        end
        idle_inputs();
        repeat (4) next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_starvation();
        test_dm_write();
        test_load_burst();
        test_read_before_load();
        test_reset_mid_load();
        test_reset();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
